// File: rtl/ph_fifo_pkg.sv
// Shared definitions for the parasite-to-host byte FIFO: default depth and Gray-code helpers.
package ph_fifo_pkg;

    localparam int unsigned PH_ADDR_W = 5;
    localparam int unsigned PH_DATA_W = 8;
    localparam int unsigned CODE_W    = 32;

    typedef logic [PH_DATA_W-1:0] ph_byte_t;

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/tube_sync2.sv
// Two-flop negedge synchroniser for a Gray-coded pointer crossing into another clock domain.
module tube_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(negedge clk or negedge rst_b) begin
        if (!rst_b) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ph_fifo.sv
// Parasite-to-host byte FIFO: parasite writes on p_phi2, host reads on h_phi2,
// Gray pointers cross through 2-flop synchronisers.
module ph_fifo
    import ph_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = PH_ADDR_W
) (
    input  logic           h_rst_b,
    input  logic           h_phi2,
    input  logic           p_phi2,
    input  logic           p_selectData,
    input  logic           p_rdnw,
    input  logic [7:0]     p_data,
    output logic           p_full,
    input  logic           h_selectData,
    input  logic           h_rdnw,
    output logic [7:0]     h_data,
    output logic           h_data_available
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt, wr_gray, rd_ptr_p, full_gray;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt, rd_gray, wr_ptr_h;
    logic             wr_en, rd_en;
    ph_byte_t         mem [DEPTH];

    // Parasite-side write pointer
    always_comb begin
        wr_en      = p_selectData & ~p_rdnw & ~p_full;
        wr_ptr_nxt = wr_ptr + PTR_W'(wr_en);
    end

    always_ff @(negedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            wr_ptr  <= '0;
            wr_gray <= '0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            wr_gray <= PTR_W'(bin2gray(CODE_W'(wr_ptr_nxt)));
        end
    end

    always_ff @(negedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            mem <= '{default: '0};
        end else if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= p_data;
        end
    end

    // Full when the write pointer is a whole lap ahead: top two Gray bits inverted
    assign full_gray = {~rd_ptr_p[PTR_W-1 -: 2], rd_ptr_p[PTR_W-3:0]};
    assign p_full    = (wr_gray == full_gray);

    // Host-side read pointer
    always_comb begin
        rd_en      = h_selectData & h_rdnw & h_data_available;
        rd_ptr_nxt = rd_ptr + PTR_W'(rd_en);
    end

    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            rd_ptr  <= '0;
            rd_gray <= '0;
        end else begin
            rd_ptr  <= rd_ptr_nxt;
            rd_gray <= PTR_W'(bin2gray(CODE_W'(rd_ptr_nxt)));
        end
    end

    assign h_data_available = (wr_ptr_h != rd_gray);
    assign h_data           = mem[rd_ptr[ADDR_W-1:0]];

    tube_sync2 #(.WIDTH(PTR_W)) u_wr_sync (
        .clk   (h_phi2),
        .rst_b (h_rst_b),
        .d     (wr_gray),
        .q     (wr_ptr_h)
    );

    tube_sync2 #(.WIDTH(PTR_W)) u_rd_sync (
        .clk   (p_phi2),
        .rst_b (h_rst_b),
        .d     (rd_gray),
        .q     (rd_ptr_p)
    );

endmodule
